// File: rtl/ysyx_24080006_axi_sram_slave_if.sv
// AXI4 slave-side bus bundle for the SRAM responder: AW, W, B, AR and R channels.
interface ysyx_24080006_axi_sram_slave_if;
  logic        awready;
  logic        awvalid;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wready;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arready;
  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rready;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;

  modport slave (
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rdata, rlast, rid,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready
  );

  modport master (
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rdata, rlast, rid,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/ysyx_24080006_axi_sram_slave.sv
// Single-outstanding AXI4 SRAM responder: round-robin AR/AW arbitration, bursts,
// byte strobes, SLVERR for out-of-range beats and for wlast/len disagreement.
module ysyx_24080006_axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0f00_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input logic clock,
  input logic reset,
  ysyx_24080006_axi_sram_slave_if.slave io_slave
);
  localparam int          IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS * 4);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, BRESP = 2'd3} state_t;

  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  state_t      state_r, state_s;
  logic        prio_wr_r, wlast_err_r, oob_r;
  logic [31:0] addr_r;
  logic [7:0]  len_r, beat_r;
  logic [2:0]  size_r;
  logic [1:0]  burst_r;
  logic        rvalid_r, rlast_r, bvalid_r;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r, bresp_r;
  logic [3:0]  rid_r, bid_r;
  logic [31:0] mem_r [DEPTH_WORDS];

  logic        idle_s, arready_s, awready_s, wready_s;
  logic        ar_hs_s, aw_hs_s, w_hs_s, r_hs_s, b_hs_s;
  logic        last_beat_s, wr_ok_s, wlast_bad_s, rd_ok_s;
  logic [31:0] next_addr_s, rd_addr_s, rd_data_s;

  // Handshake qualification and beat address generation.
  always_comb begin
    idle_s      = (state_r == IDLE) && !reset;
    arready_s   = idle_s && !(io_slave.awvalid && prio_wr_r);
    awready_s   = idle_s && !(io_slave.arvalid && !prio_wr_r);
    wready_s    = (state_r == WR) && !reset;
    ar_hs_s     = io_slave.arvalid && arready_s;
    aw_hs_s     = io_slave.awvalid && awready_s && !ar_hs_s;
    w_hs_s      = io_slave.wvalid && wready_s;
    r_hs_s      = rvalid_r && io_slave.rready;
    b_hs_s      = bvalid_r && io_slave.bready;
    last_beat_s = (beat_r == len_r);
    wr_ok_s     = in_range(addr_r);
    wlast_bad_s = io_slave.wlast != last_beat_s;
    // FIXED holds the address; WRAP is deliberately treated as INCR.
    next_addr_s = (burst_r == 2'b00) ? addr_r : addr_r + (32'd1 << size_r);
    rd_addr_s   = (state_r == IDLE) ? io_slave.araddr : next_addr_s;
    rd_ok_s     = in_range(rd_addr_s);
    rd_data_s   = rd_ok_s ? mem_r[word_idx(rd_addr_s)] : 32'd0;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ar_hs_s) begin
          state_s = RD;
        end else if (aw_hs_s) begin
          state_s = WR;
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        if (r_hs_s && rlast_r) begin
          state_s = IDLE;
        end else begin
          state_s = RD;
        end
      end
      WR: begin
        if (w_hs_s && last_beat_s) begin
          state_s = BRESP;
        end else begin
          state_s = WR;
        end
      end
      BRESP: begin
        if (b_hs_s) begin
          state_s = IDLE;
        end else begin
          state_s = BRESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Burst bookkeeping and registered R/B channel outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      prio_wr_r   <= 1'b0;
      wlast_err_r <= 1'b0;
      oob_r       <= 1'b0;
      addr_r      <= 32'd0;
      len_r       <= 8'd0;
      beat_r      <= 8'd0;
      size_r      <= 3'd0;
      burst_r     <= 2'd0;
      rvalid_r    <= 1'b0;
      rlast_r     <= 1'b0;
      rdata_r     <= 32'd0;
      rresp_r     <= OKAY;
      rid_r       <= 4'd0;
      bvalid_r    <= 1'b0;
      bresp_r     <= OKAY;
      bid_r       <= 4'd0;
    end else if (ar_hs_s) begin
      prio_wr_r <= 1'b0;
      addr_r    <= io_slave.araddr;
      len_r     <= io_slave.arlen;
      size_r    <= io_slave.arsize;
      burst_r   <= io_slave.arburst;
      beat_r    <= 8'd0;
      rvalid_r  <= 1'b1;
      rdata_r   <= rd_data_s;
      rresp_r   <= rd_ok_s ? OKAY : SLVERR;
      rlast_r   <= (io_slave.arlen == 8'd0);
      rid_r     <= io_slave.arid;
    end else if (aw_hs_s) begin
      prio_wr_r   <= 1'b1;
      addr_r      <= io_slave.awaddr;
      len_r       <= io_slave.awlen;
      size_r      <= io_slave.awsize;
      burst_r     <= io_slave.awburst;
      beat_r      <= 8'd0;
      wlast_err_r <= 1'b0;
      oob_r       <= 1'b0;
      bid_r       <= io_slave.awid;
    end else if (r_hs_s) begin
      if (rlast_r) begin
        rvalid_r <= 1'b0;
      end else begin
        beat_r  <= beat_r + 8'd1;
        addr_r  <= next_addr_s;
        rdata_r <= rd_data_s;
        rresp_r <= rd_ok_s ? OKAY : SLVERR;
        rlast_r <= ((beat_r + 8'd1) == len_r);
      end
    end else if (w_hs_s) begin
      beat_r <= beat_r + 8'd1;
      addr_r <= next_addr_s;
      if (wlast_bad_s) begin
        wlast_err_r <= 1'b1;
      end
      if (!wr_ok_s) begin
        oob_r <= 1'b1;
      end
      if (last_beat_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= (oob_r || !wr_ok_s || wlast_err_r || wlast_bad_s) ? SLVERR : OKAY;
      end
    end else if (b_hs_s) begin
      bvalid_r <= 1'b0;
    end
  end

  // Storage array; not reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (w_hs_s && wr_ok_s) begin
      for (int b = 0; b < 4; b++) begin
        if (io_slave.wstrb[b]) begin
          mem_r[word_idx(addr_r)][8*b +: 8] <= io_slave.wdata[8*b +: 8];
        end
      end
    end
  end

  assign io_slave.arready = arready_s;
  assign io_slave.awready = awready_s;
  assign io_slave.wready  = wready_s;
  assign io_slave.rvalid  = rvalid_r;
  assign io_slave.rdata   = rdata_r;
  assign io_slave.rresp   = rresp_r;
  assign io_slave.rlast   = rlast_r;
  assign io_slave.rid     = rid_r;
  assign io_slave.bvalid  = bvalid_r;
  assign io_slave.bresp   = bresp_r;
  assign io_slave.bid     = bid_r;
endmodule

// File: tb/tb_ysyx_24080006_axi_sram_slave.sv
// Bench for the AXI SRAM responder: word-array memory model and expected-beat
// queues checked every cycle, plus literal expectations for the directed cases.
module tb_ysyx_24080006_axi_sram_slave;
  localparam logic [31:0] BASE  = 32'h0f00_0000;
  localparam int          DEPTH = 1024;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_24080006_axi_sram_slave_if io();

  ysyx_24080006_axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clock   (clock),
    .reset   (reset),
    .io_slave(io.slave)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] model_mem [int];
  logic [31:0] wbuf [256];
  logic [31:0] last_rdata;
  logic [1:0]  last_rresp, last_bresp;
  logic        last_rlast;
  logic [3:0]  last_bid;
  int          r_pops = 0;
  int          rlast_pops = 0;
  int          rl0;
  bit          ok;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                            input logic [2:0] sz, input logic [1:0] bu);
    if (bu == 2'b00) return a;
    return a + (32'(i) << sz);
  endfunction

  function automatic bit inr(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Apply a write burst to the model and queue the B response it must produce.
  task automatic model_write(input logic [31:0] a, input logic [3:0] id, input int len,
                             input logic [2:0] sz, input logic [1:0] bu,
                             input logic [3:0] strb, input int bad);
    bexp_t       e;
    logic [31:0] ba, w;
    e.resp = 2'b00;
    e.id   = id;
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(a, i, sz, bu);
      if (i == bad) e.resp = 2'b10;
      if (!inr(ba)) begin
        e.resp = 2'b10;
      end else begin
        w = model_mem.exists(widx(ba)) ? model_mem[widx(ba)] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (strb[b]) w[8*b +: 8] = wbuf[i][8*b +: 8];
        model_mem[widx(ba)] = w;
      end
    end
    bq.push_back(e);
  endtask

  task automatic push_read(input logic [31:0] a, input logic [3:0] id, input int len,
                           input logic [2:0] sz, input logic [1:0] bu);
    rbeat_t      e;
    logic [31:0] ba;
    for (int i = 0; i <= len; i++) begin
      ba     = beat_addr(a, i, sz, bu);
      e.data = inr(ba) ? model_mem[widx(ba)] : 32'h0;
      e.resp = inr(ba) ? 2'b00 : 2'b10;
      e.last = (i == len);
      e.id   = id;
      rq.push_back(e);
    end
  endtask

  task automatic ar_req(input logic [31:0] a, input logic [3:0] id, input int len,
                        input logic [2:0] sz, input logic [1:0] bu);
    io.araddr = a; io.arid = id; io.arlen = 8'(len); io.arsize = sz; io.arburst = bu;
    io.arvalid = 1'b1;
  endtask

  task automatic aw_req(input logic [31:0] a, input logic [3:0] id, input int len,
                        input logic [2:0] sz, input logic [1:0] bu);
    io.awaddr = a; io.awid = id; io.awlen = 8'(len); io.awsize = sz; io.awburst = bu;
    io.awvalid = 1'b1;
  endtask

  task automatic ar_wait();
    bit got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clock);
      if (io.arready === 1'b1) got = 1'b1;
    end
    chk("ar_accept", 32'(got), 32'd1);
    @(posedge clock); #1;
    io.arvalid = 1'b0;
  endtask

  task automatic aw_wait();
    bit got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clock);
      if (io.awready === 1'b1) got = 1'b1;
    end
    chk("aw_accept", 32'(got), 32'd1);
    @(posedge clock); #1;
    io.awvalid = 1'b0;
  endtask

  task automatic w_send(input int len, input logic [3:0] strb, input int bad);
    bit got;
    for (int i = 0; i <= len; i++) begin
      io.wvalid = 1'b1; io.wdata = wbuf[i]; io.wstrb = strb;
      io.wlast  = (i == len) ^ (i == bad);
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
        @(negedge clock);
        if (io.wready === 1'b1) got = 1'b1;
      end
      if (!got) chk("w_accept", 32'(got), 32'd1);
      @(posedge clock); #1;
    end
    io.wvalid = 1'b0; io.wlast = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    bit done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(posedge clock);
      if (rq.size() == 0 && bq.size() == 0) done = 1'b1;
      #1;
      if (toggle && !done) io.rready = ~io.rready;
    end
    chk("drain", 32'(done), 32'd1);
    io.rready = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id, input int len,
                          input logic [2:0] sz, input logic [1:0] bu,
                          input logic [3:0] strb, input int bad);
    model_write(a, id, len, sz, bu, strb, bad);
    aw_req(a, id, len, sz, bu);
    aw_wait();
    w_send(len, strb, bad);
    drain(1'b0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input int len,
                         input logic [2:0] sz, input logic [1:0] bu, input bit toggle);
    push_read(a, id, len, sz, bu);
    ar_req(a, id, len, sz, bu);
    ar_wait();
    drain(toggle);
  endtask

  // Compare process: every visible R or B beat must match the head of its queue.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (io.rvalid === 1'b1) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", 32'(io.rvalid), 32'd0);
        end else begin
          chk("rdata", io.rdata, rq[0].data);
          chk("rresp", 32'(io.rresp), 32'(rq[0].resp));
          chk("rlast", 32'(io.rlast), 32'(rq[0].last));
          chk("rid", 32'(io.rid), 32'(rq[0].id));
          if (io.rready === 1'b1) begin
            last_rdata = io.rdata; last_rresp = io.rresp; last_rlast = io.rlast;
            if (rq[0].last) rlast_pops++;
            r_pops++;
            void'(rq.pop_front());
          end
        end
      end
      if (io.bvalid === 1'b1) begin
        if (bq.size() == 0) begin
          chk("b_unexpected", 32'(io.bvalid), 32'd0);
        end else begin
          chk("bresp", 32'(io.bresp), 32'(bq[0].resp));
          chk("bid", 32'(io.bid), 32'(bq[0].id));
          if (io.bready === 1'b1) begin
            last_bresp = io.bresp; last_bid = io.bid;
            void'(bq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    io.awvalid = 1'b0; io.awaddr = 32'h0; io.awid = 4'h0; io.awlen = 8'h0;
    io.awsize = 3'd0; io.awburst = 2'b00;
    io.arvalid = 1'b0; io.araddr = 32'h0; io.arid = 4'h0; io.arlen = 8'h0;
    io.arsize = 3'd0; io.arburst = 2'b00;
    io.wvalid = 1'b0; io.wdata = 32'h0; io.wstrb = 4'h0; io.wlast = 1'b0;
    io.rready = 1'b1; io.bready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_arready", 32'(io.arready), 32'd0);
    chk("rst_awready", 32'(io.awready), 32'd0);
    chk("rst_wready", 32'(io.wready), 32'd0);
    chk("rst_rvalid", 32'(io.rvalid), 32'd0);
    chk("rst_bvalid", 32'(io.bvalid), 32'd0);
    chk("rst_rlast", 32'(io.rlast), 32'd0);
    chk("rst_rdata", io.rdata, 32'd0);
    chk("rst_rresp", 32'(io.rresp), 32'd0);
    chk("rst_bresp", 32'(io.bresp), 32'd0);
    chk("rst_rid", 32'(io.rid), 32'd0);
    chk("rst_bid", 32'(io.bid), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Single write then read.
    wbuf[0] = 32'hDEADBEEF;
    do_write(BASE + 32'h10, 4'd1, 0, 3'd2, 2'b01, 4'hF, -1);
    chk("single_bresp", 32'(last_bresp), 32'd0);
    do_read(BASE + 32'h10, 4'd2, 0, 3'd2, 2'b01, 1'b0);
    chk("single_rdata", last_rdata, 32'hDEADBEEF);
    chk("single_rlast", 32'(last_rlast), 32'd1);
    chk("single_rresp", 32'(last_rresp), 32'd0);

    // INCR burst, read back with rready toggling.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(BASE, 4'd3, 3, 3'd2, 2'b01, 4'hF, -1);
    rl0 = rlast_pops;
    do_read(BASE, 4'd4, 3, 3'd2, 2'b01, 1'b1);
    chk("incr_last_data", last_rdata, 32'd4);
    chk("incr_rlast_count", 32'(rlast_pops - rl0), 32'd1);

    // Strobe merge.
    wbuf[0] = 32'h11223344;
    do_write(BASE + 32'h40, 4'd5, 0, 3'd2, 2'b01, 4'hF, -1);
    wbuf[0] = 32'hAABBCCDD;
    do_write(BASE + 32'h40, 4'd5, 0, 3'd2, 2'b01, 4'b0101, -1);
    do_read(BASE + 32'h40, 4'd6, 0, 3'd2, 2'b01, 1'b0);
    chk("strobe_merge", last_rdata, 32'h11BB33DD);

    // FIXED burst, and byte-size INCR reads hitting one word.
    wbuf[0] = 32'hF1; wbuf[1] = 32'hF2; wbuf[2] = 32'hF3;
    do_write(BASE + 32'h80, 4'd7, 2, 3'd2, 2'b00, 4'hF, -1);
    do_read(BASE + 32'h80, 4'd8, 1, 3'd2, 2'b00, 1'b0);
    chk("fixed_data", last_rdata, 32'h000000F3);
    do_read(BASE, 4'd9, 3, 3'd0, 2'b01, 1'b0);
    chk("byte_incr_data", last_rdata, 32'd1);

    // Error cases: past the end, burst crossing the end, early wlast.
    do_read(BASE + 32'(DEPTH * 4), 4'd7, 0, 3'd2, 2'b01, 1'b0);
    chk("oob_rresp", 32'(last_rresp), 32'd2);
    chk("oob_rdata", last_rdata, 32'd0);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    do_write(BASE + 32'hFF8, 4'd10, 3, 3'd2, 2'b11, 4'hF, -1);
    chk("cross_bresp", 32'(last_bresp), 32'd2);
    do_read(BASE + 32'hFF8, 4'd11, 3, 3'd2, 2'b01, 1'b0);
    chk("cross_rresp", 32'(last_rresp), 32'd2);
    wbuf[0] = 32'h0BAD0000; wbuf[1] = 32'h0BAD0001;
    do_write(BASE + 32'h60, 4'd9, 1, 3'd2, 2'b01, 4'hF, 0);
    chk("wlast_bresp", 32'(last_bresp), 32'd2);
    chk("wlast_bid", 32'(last_bid), 32'd9);

    // 256-beat bursts.
    for (int i = 0; i < 256; i++) wbuf[i] = 32'h1000_0000 + 32'(i * 3);
    do_write(BASE + 32'h400, 4'd12, 255, 3'd2, 2'b01, 4'hF, -1);
    rl0 = rlast_pops;
    do_read(BASE + 32'h400, 4'd13, 255, 3'd2, 2'b01, 1'b0);
    chk("len255_last", last_rdata, 32'h1000_02FD);
    chk("len255_rlast_count", 32'(rlast_pops - rl0), 32'd1);

    // Reset during beat 2 of a len-7 read.
    push_read(BASE + 32'h400, 4'd4, 7, 3'd2, 2'b01);
    r_pops = 0;
    ar_req(BASE + 32'h400, 4'd4, 7, 3'd2, 2'b01);
    ar_wait();
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(posedge clock);
      if (r_pops >= 2) ok = 1'b1;
    end
    chk("reset_reach_beat2", 32'(ok), 32'd1);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_rvalid", 32'(io.rvalid), 32'd0);
    chk("midrst_rdata", io.rdata, 32'd0);
    rq.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    do_read(BASE + 32'h40C, 4'd5, 1, 3'd2, 2'b01, 1'b0);
    chk("post_reset_read", last_rdata, 32'h1000_000C);

    // Arbitration after reset: read wins first, then the write gets priority.
    push_read(BASE + 32'h10, 4'd3, 0, 3'd2, 2'b01);
    ar_req(BASE + 32'h10, 4'd3, 0, 3'd2, 2'b01);
    aw_req(BASE + 32'h20, 4'd6, 0, 3'd2, 2'b01);
    @(negedge clock);
    chk("prio1_arready", 32'(io.arready), 32'd1);
    chk("prio1_awready", 32'(io.awready), 32'd0);
    @(posedge clock); #1;
    io.arvalid = 1'b0;
    drain(1'b0);
    chk("prio1_rdata", last_rdata, 32'hDEADBEEF);
    wbuf[0] = 32'h5555AAAA;
    model_write(BASE + 32'h20, 4'd6, 0, 3'd2, 2'b01, 4'hF, -1);
    aw_wait();
    w_send(0, 4'hF, -1);
    drain(1'b0);
    wbuf[0] = 32'h7777_1234;
    model_write(BASE + 32'h24, 4'd8, 0, 3'd2, 2'b01, 4'hF, -1);
    push_read(BASE + 32'h24, 4'd9, 0, 3'd2, 2'b01);
    ar_req(BASE + 32'h24, 4'd9, 0, 3'd2, 2'b01);
    aw_req(BASE + 32'h24, 4'd8, 0, 3'd2, 2'b01);
    @(negedge clock);
    chk("prio2_arready", 32'(io.arready), 32'd0);
    chk("prio2_awready", 32'(io.awready), 32'd1);
    @(posedge clock); #1;
    io.awvalid = 1'b0;
    w_send(0, 4'hF, -1);
    ar_wait();
    drain(1'b0);
    chk("raw_rdata", last_rdata, 32'h7777_1234);
    chk("raw_bid", 32'(last_bid), 32'd8);

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
